// File: rtl/mac_operand_loader.sv
// mac_operand_loader: gathers operand A then operand B from a word-serial
// stream and presents the completed pair to the MAC with its own handshake.
// A staging buffer sits in front of the output registers, so the next pair
// can stream in while the MAC is still holding the current one.
// Build option: LOADER_MSW_FIRST_EN places word 0 in the most-significant
// slice instead of the least-significant slice.
//
// state  | meaning
// FILL_A | collecting words of operand A into stage_a
// FILL_B | collecting words of operand B into stage_b
// FULL   | staging holds a complete pair waiting for the output slot
module mac_operand_loader #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              frame_err,
  output logic [15:0]       pair_cnt
);

  localparam int WORDS = OP_W / WORD_W;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W = (OP_W > 1) ? $clog2(OP_W) : 1;

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [KW-1:0]     word_idx;
  logic [OP_W-1:0]   stage_a, stage_b;
  logic [OP_W-1:0]   b_merged;
  logic [OFF_W-1:0]  slice_base;
  logic              word_fire, pair_fire, last_word, slot_free;
  logic              load_stream, load_stage;

  assign in_ready  = (state != FULL);
  assign word_fire = in_valid & in_ready;
  assign pair_fire = op_valid & op_ready;
  assign slot_free = ~op_valid | op_ready;
  assign last_word = (word_idx == KW'(WORDS - 1));

  // Bit offset of the current word, plus operand B with that word already
  // merged in so a finishing pair can go straight to the output registers.
  always_comb begin
`ifdef LOADER_MSW_FIRST_EN
    slice_base = OFF_W'(OP_W - WORD_W) - OFF_W'(word_idx) * OFF_W'(WORD_W);
`else
    slice_base = OFF_W'(word_idx) * OFF_W'(WORD_W);
`endif
    b_merged = stage_b;
    b_merged[slice_base +: WORD_W] = in_data;
  end

  // Staging state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL_A;
    else     state <= state_nxt;
  end

  // Next-state decode and output-slot load selection.
  always_comb begin
    state_nxt   = state;
    load_stream = 1'b0;
    load_stage  = 1'b0;
    case (state)
      FILL_A: if (word_fire && last_word) state_nxt = FILL_B;
      FILL_B: begin
        if (word_fire && last_word) begin
          if (slot_free) begin
            state_nxt   = FILL_A;
            load_stream = 1'b1;
          end else begin
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        // op_valid is always set while FULL, so op_ready alone means accept.
        if (op_ready) begin
          state_nxt  = FILL_A;
          load_stage = 1'b1;
        end
      end
      default: state_nxt = FILL_A;
    endcase
  end

  // Word index, staging writes and the sticky framing check.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx  <= '0;
      stage_a   <= '0;
      stage_b   <= '0;
      frame_err <= 1'b0;
    end else if (word_fire) begin
      word_idx <= last_word ? '0 : word_idx + KW'(1);
      if (state == FILL_A) stage_a[slice_base +: WORD_W] <= in_data;
      else                 stage_b[slice_base +: WORD_W] <= in_data;
      if (in_last != ((state == FILL_B) && last_word)) frame_err <= 1'b1;
    end
  end

  // Output pair registers, valid flag and delivered-pair counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      pair_cnt <= '0;
    end else begin
      if (load_stream) begin
        op_a     <= stage_a;
        op_b     <= b_merged;
        op_valid <= 1'b1;
      end else if (load_stage) begin
        op_a     <= stage_a;
        op_b     <= stage_b;
        op_valid <= 1'b1;
      end else if (pair_fire) begin
        op_valid <= 1'b0;
      end
      if (pair_fire) pair_cnt <= pair_cnt + 16'd1;
    end
  end

endmodule
